// File: rtl/bicubic_tap_feeder.sv
// bicubic_tap_feeder
//   Turns a raster pixel stream, one row at a time, into 4-pixel windows
//   {p[x-1], p[x], p[x+1], p[x+2]} for each output column x. These windows
//   feed the 4-tap bicubic weight tables. Pixels outside the row are filled
//   by replicating the edge pixel. When TAP_ZERO_PAD_EN is defined, they are
//   filled with zero instead.
// Ports
//   clk_i, rst_i                    clock and asynchronous active-high reset
//   pix_in_i, pix_valid_i           input pixel stream
//   pix_ready_o                     input accept (combinational)
//   tap_0_o..tap_3_o                window p[x-1], p[x], p[x+1], p[x+2] (registered)
//   tap_x_o                         column x of the current window (registered)
//   tap_valid_o, tap_last_o         window valid / window is x = LINE_W-1 (registered)
//   tap_ready_i                     consumer takes the window
// Configuration macro: TAP_ZERO_PAD_EN (zero padding instead of edge replication).
module bicubic_tap_feeder #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned LINE_W = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PIX_W-1:0] pix_in_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] tap_0_o,
  output logic [PIX_W-1:0] tap_1_o,
  output logic [PIX_W-1:0] tap_2_o,
  output logic [PIX_W-1:0] tap_3_o,
  output logic [CNT_W-1:0] tap_x_o,
  output logic             tap_valid_o,
  output logic             tap_last_o,
  input  logic             tap_ready_i
);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(LINE_W - 1);

  state_e                 state_q, state_d;
  logic [3:0][PIX_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;   // index of the next pixel expected in the row
  logic [CNT_W-1:0]       x_q, x_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   flush2_q, flush2_d;  // set while the second flush cycle is pending

  logic                   adv;
  logic                   acc;
  logic [PIX_W-1:0]       fill_val;
  logic [PIX_W-1:0]       flush_val;

  // The output register may be overwritten when it is empty or being taken.
  assign adv         = ~valid_q | tap_ready_i;
  assign pix_ready_o = adv & (state_q != StFlush);
  assign acc         = pix_valid_i & pix_ready_o;

`ifdef TAP_ZERO_PAD_EN
  assign fill_val  = '0;
  assign flush_val = '0;
`else
  assign fill_val  = pix_in_i;
  assign flush_val = sr_q[3];
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      flush2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      flush2_q <= flush2_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (acc) state_d = StFill;
      StFill:  if (acc) state_d = StRun;
      StRun:   if (acc && (cnt_q == LastIdx)) state_d = StFlush;
      StFlush: if (adv && flush2_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    last_d   = last_q;
    flush2_d = flush2_q;
    // A taken window drops valid unless a new one is loaded below.
    valid_d  = valid_q & ~tap_ready_i;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          sr_d   = {pix_in_i, fill_val, fill_val, fill_val};
          cnt_d  = CNT_W'(1);
          x_d    = '0;
          last_d = 1'b0;
        end
      end
      StFill: begin
        if (acc) begin
          sr_d  = {pix_in_i, sr_q[3], sr_q[2], sr_q[1]};
          cnt_d = CNT_W'(2);
        end
      end
      StRun: begin
        if (acc) begin
          sr_d    = {pix_in_i, sr_q[3], sr_q[2], sr_q[1]};
          valid_d = 1'b1;
          x_d     = cnt_q - CNT_W'(2);
          last_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StFlush: begin
        if (adv) begin
          sr_d     = {flush_val, sr_q[3], sr_q[2], sr_q[1]};
          valid_d  = 1'b1;
          x_d      = x_q + CNT_W'(1);
          last_d   = flush2_q;
          flush2_d = ~flush2_q;
        end
      end
      default: ;
    endcase
  end

  assign tap_0_o     = sr_q[0];
  assign tap_1_o     = sr_q[1];
  assign tap_2_o     = sr_q[2];
  assign tap_3_o     = sr_q[3];
  assign tap_x_o     = x_q;
  assign tap_valid_o = valid_q;
  assign tap_last_o  = last_q;

endmodule
